// File: rtl/fetch_stage_pkg.sv
// Shared constants for the IF stage: reset vector, bubble encoding, memory size
// and the fetch-FSM state encodings.
package fetch_stage_pkg;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_IMEM_BYTES   = 32'h0010_0000;
   localparam logic [31:0] DEF_NOP_INSTR    = 32'h0000_0013;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   // A fetch faults when it leaves the memory or is not word aligned.
   function automatic logic fetch_faults(input logic [31:0] adr,
                                         input logic [31:0] imem_bytes);
      return (adr >= imem_bytes) || (adr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction, holds it, or
// replaces it with a bubble.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] pc_p0,
   input  logic [31:0] instr_p0,
   input  logic        fault_p0,
   output logic [31:0] pc_p1,
   output logic [31:0] pc_plus4_p1,
   output logic [31:0] instr_p1,
   output logic        fault_p1,
   output logic        vld_p1
);

   // IF -> ID boundary
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         pc_p1       <= 32'h0;
         pc_plus4_p1 <= 32'h0;
         instr_p1    <= NOP_INSTR;
         fault_p1    <= 1'b0;
         vld_p1      <= 1'b0;
      end else if (load && !hold) begin
         pc_p1       <= pc_p0;
         pc_plus4_p1 <= pc_p0 + 32'd4;
         instr_p1    <= instr_p0;
         fault_p1    <= fault_p0;
         vld_p1      <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and fetch FSM, resolves trap/redirect/flush/stall
// priority and feeds the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] IMEM_BYTES   = DEF_IMEM_BYTES,
   parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_target,
   input  logic        i_trap_valid,
   input  logic [31:0] i_trap_vector,
   input  logic        i_halt,
   output logic [31:0] o_imem_adr,
   input  logic [31:0] i_imem_instr,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc_plus4,
   output logic [31:0] o_if_id_instr,
   output logic        o_if_id_valid,
   output logic        o_if_id_fault,
   output logic        o_misaligned,
   output logic [31:0] o_misaligned_adr
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  state_q, state_d;
   logic [31:0] pc_inc;
   logic        fault_p0;
   logic [31:0] instr_p0;
   logic        redir_ok, redir_bad;
   logic        ifid_load, ifid_hold, ifid_bubble;
   logic        mis_set;

   assign o_imem_adr = pc_q;
   assign pc_inc     = pc_q + 32'd4;
   assign fault_p0   = fetch_faults(pc_q, IMEM_BYTES);
   assign instr_p0   = fault_p0 ? NOP_INSTR : i_imem_instr;
   assign redir_ok   = i_redirect_valid && (i_redirect_target[1:0] == 2'b00);
   assign redir_bad  = i_redirect_valid && (i_redirect_target[1:0] != 2'b00);

   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      ifid_load   = 1'b0;
      ifid_hold   = 1'b0;
      ifid_bubble = 1'b0;
      mis_set     = 1'b0;
      case (state_q)
         S_BOOT: begin
            ifid_bubble = 1'b1;
            state_d     = S_RUN;
         end
         S_RUN: begin
            if (i_trap_valid) begin
               pc_d        = i_trap_vector;
               ifid_bubble = 1'b1;
            end else if (redir_ok) begin
               pc_d        = i_redirect_target;
               ifid_bubble = 1'b1;
            end else begin
               // A rejected redirect falls through to the ordinary rules.
               mis_set = redir_bad;
               if (i_flush) begin
                  ifid_bubble = 1'b1;
                  if (!i_stall) pc_d = pc_inc;
               end else if (i_stall) begin
                  ifid_hold = 1'b1;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_inc;
               end
               if (i_halt && !i_stall) state_d = S_HALT;
            end
         end
         S_HALT: begin
            ifid_bubble = 1'b1;
            if (i_trap_valid) begin
               pc_d    = i_trap_vector;
               state_d = S_RUN;
            end else if (redir_ok) begin
               pc_d    = i_redirect_target;
               state_d = S_RUN;
            end else begin
               mis_set = redir_bad;
            end
         end
         default: begin
            ifid_bubble = 1'b1;
            state_d     = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q             <= RESET_VECTOR;
         state_q          <= S_BOOT;
         o_misaligned     <= 1'b0;
         o_misaligned_adr <= 32'h0;
      end else begin
         pc_q         <= pc_d;
         state_q      <= state_d;
         o_misaligned <= mis_set;
         if (mis_set) o_misaligned_adr <= i_redirect_target;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk         (i_clk),
      .rst         (i_rst),
      .load        (ifid_load),
      .hold        (ifid_hold),
      .bubble      (ifid_bubble),
      .pc_p0       (pc_q),
      .instr_p0    (instr_p0),
      .fault_p0    (fault_p0),
      .pc_p1       (o_if_id_pc),
      .pc_plus4_p1 (o_if_id_pc_plus4),
      .instr_p1    (o_if_id_instr),
      .fault_p1    (o_if_id_fault),
      .vld_p1      (o_if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues expected IF/ID captures,
// the monitor pops one per new valid IF/ID entry.
module tb_fetch_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } cap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, halt = 1'b0;
   logic        rv = 1'b0, tv = 1'b0;
   logic [31:0] tgt = 32'h0, vec = 32'h0;
   logic [31:0] imem_adr, imem_instr;
   logic [31:0] if_pc, if_pc4, if_instr, mis_adr;
   logic        if_valid, if_fault, mis;

   int   checks = 0;
   int   failures = 0;
   cap_t expq[$];

   always #5 clk = ~clk;

   // Word 0 holds the test-plan instruction; elsewhere a tag plus low address bits.
   assign imem_instr = (imem_adr == 32'h0) ? 32'h0050_0093 : {16'hC0DE, imem_adr[15:0]};

   fetch_stage dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_stall           (stall),
      .i_flush           (flush),
      .i_redirect_valid  (rv),
      .i_redirect_target (tgt),
      .i_trap_valid      (tv),
      .i_trap_vector     (vec),
      .i_halt            (halt),
      .o_imem_adr        (imem_adr),
      .i_imem_instr      (imem_instr),
      .o_if_id_pc        (if_pc),
      .o_if_id_pc_plus4  (if_pc4),
      .o_if_id_instr     (if_instr),
      .o_if_id_valid     (if_valid),
      .o_if_id_fault     (if_fault),
      .o_misaligned      (mis),
      .o_misaligned_adr  (mis_adr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
      cap_t c;
      c.pc = pc; c.instr = instr; c.fault = fault;
      expq.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a new IF/ID entry is a valid one whose PC differs from the last sample.
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc = 32'h0;
   always @(posedge clk) begin
      cap_t e;
      #2;
      if (if_valid === 1'b1 && (!prev_valid || if_pc !== prev_pc)) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_capture: got pc %08h expected no capture", if_pc);
         end else begin
            e = expq.pop_front();
            check("cap_pc", if_pc, e.pc);
            check("cap_pc_plus4", if_pc4, e.pc + 32'd4);
            check("cap_instr", if_instr, e.instr);
            check("cap_fault", {31'h0, if_fault}, {31'h0, e.fault});
         end
      end
      prev_valid = (if_valid === 1'b1);
      prev_pc    = if_pc;
   end

   task automatic check_reset_state();
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_instr", if_instr, 32'h0000_0013);
      check("rst_pc", if_pc, 32'h0);
      check("rst_pc4", if_pc4, 32'h0);
      check("rst_fault", {31'h0, if_fault}, 32'h0);
      check("rst_mis", {31'h0, mis}, 32'h0);
      check("rst_mis_adr", mis_adr, 32'h0);
      check("rst_adr", imem_adr, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, boot bubble, then free run.
      step();
      check_reset_state();
      rst = 1'b0;
      step();
      check("boot_valid", {31'h0, if_valid}, 32'h0);
      check("boot_adr", imem_adr, 32'h0);
      push(32'h0, 32'h0050_0093, 1'b0);
      step();
      check("run_adr4", imem_adr, 32'h4);
      push(32'h4, 32'hC0DE_0004, 1'b0);
      step();
      check("run_adr8", imem_adr, 32'h8);
      push(32'h8, 32'hC0DE_0008, 1'b0);
      step();
      push(32'hC, 32'hC0DE_000C, 1'b0);
      step();
      check("run_adr10", imem_adr, 32'h10);

      // Stall three cycles at 0x10.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_adr", imem_adr, 32'h10);
         check("stall_pc", if_pc, 32'hC);
         check("stall_instr", if_instr, 32'hC0DE_000C);
      end
      stall = 1'b0;
      push(32'h10, 32'hC0DE_0010, 1'b0);
      step();
      check("unstall_pc", if_pc, 32'h10);

      // Redirect overrides a stall.
      stall = 1'b1; rv = 1'b1; tgt = 32'h40;
      step();
      check("redir_adr", imem_adr, 32'h40);
      check("redir_valid", {31'h0, if_valid}, 32'h0);
      stall = 1'b0; rv = 1'b0;
      push(32'h40, 32'hC0DE_0040, 1'b0);
      step();
      check("redir_follow_adr", imem_adr, 32'h44);

      // Misaligned redirect is rejected; fetch continues sequentially.
      rv = 1'b1; tgt = 32'h42;
      push(32'h44, 32'hC0DE_0044, 1'b0);
      step();
      check("mis_pulse", {31'h0, mis}, 32'h1);
      check("mis_adr", mis_adr, 32'h42);
      check("mis_pc_adv", imem_adr, 32'h48);
      rv = 1'b0;
      push(32'h48, 32'hC0DE_0048, 1'b0);
      step();
      check("mis_pulse_end", {31'h0, mis}, 32'h0);
      check("mis_adr_held", mis_adr, 32'h42);

      // Trap beats redirect.
      tv = 1'b1; vec = 32'h100; rv = 1'b1; tgt = 32'h40;
      step();
      check("trap_adr", imem_adr, 32'h100);
      check("trap_valid", {31'h0, if_valid}, 32'h0);
      tv = 1'b0; rv = 1'b0;
      push(32'h100, 32'hC0DE_0100, 1'b0);
      step();

      // Halt at 0x20: parks at 0x24, stall/flush ignored.
      rv = 1'b1; tgt = 32'h20;
      step();
      rv = 1'b0; halt = 1'b1;
      push(32'h20, 32'hC0DE_0020, 1'b0);
      step();
      check("halt_adr", imem_adr, 32'h24);
      halt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         flush = (i == 3); stall = (i == 5);
         step();
         check("halt_park_adr", imem_adr, 32'h24);
         check("halt_valid", {31'h0, if_valid}, 32'h0);
      end
      flush = 1'b0; stall = 1'b0;
      tv = 1'b1; vec = 32'h100;
      step();
      check("wake_adr", imem_adr, 32'h100);
      tv = 1'b0;
      push(32'h100, 32'hC0DE_0100, 1'b0);
      step();
      check("wake_run_adr", imem_adr, 32'h104);

      // Last in-range word, then out-of-range fault.
      tv = 1'b1; vec = 32'h000F_FFFC;
      step();
      tv = 1'b0;
      push(32'h000F_FFFC, 32'hC0DE_FFFC, 1'b0);
      step();
      check("edge_adr", imem_adr, 32'h0010_0000);
      push(32'h0010_0000, 32'h0000_0013, 1'b1);
      step();
      check("fault_flag", {31'h0, if_fault}, 32'h1);

      // PC wrap.
      tv = 1'b1; vec = 32'hFFFF_FFFC;
      step();
      tv = 1'b0;
      push(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
      step();
      check("wrap_adr", imem_adr, 32'h0);
      check("wrap_pc4", if_pc4, 32'h0);

      // Flush: bubble while the PC still advances.
      flush = 1'b1;
      step();
      check("flush_valid", {31'h0, if_valid}, 32'h0);
      check("flush_adr", imem_adr, 32'h4);
      flush = 1'b0;

      // Halt then reset from S_HALT.
      halt = 1'b1;
      push(32'h4, 32'hC0DE_0004, 1'b0);
      step();
      halt = 1'b0;
      step();
      check("halt2_adr", imem_adr, 32'h8);
      rst = 1'b1;
      step();
      check_reset_state();
      rst = 1'b0;
      step();
      step();

      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
